// File: rtl/ahb_lite_master.sv
// Bus initiator that turns cache line bursts and single uncached accesses into word beats.
// Optional per-beat timeout abort is built only when AHB_TIMEOUT_EN is defined.
module ahb_lite_master #(
  parameter int WORDS_PER_LINE = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic                              req_burst,
  input  logic [31:0]                       req_addr,
  input  logic [2:0]                        req_size,
  output logic [$clog2(WORDS_PER_LINE)-1:0] beat_idx,
  input  logic [31:0]                       wr_data,
  output logic [31:0]                       rd_data,
  output logic                              rd_valid,
  output logic                              done,
  output logic                              err,
  output logic                              HREQUEST,
  output logic                              HWRITE,
  output logic [2:0]                        HSIZE,
  output logic [31:0]                       HADDR,
  output logic [31:0]                       HWDATA,
  input  logic [31:0]                       HRDATA,
  input  logic                              HREADY
);

  localparam int IDX_W = $clog2(WORDS_PER_LINE);
  localparam logic [31:0] LINE_MASK = ~(32'(WORDS_PER_LINE * 4) - 32'd1);

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             beat_done;
  logic             last_beat;
  logic             timeout_hit;
  logic             abort_q;
  logic             burst_q;
  logic             hwrite_q;
  logic [2:0]       hsize_q;
  logic [31:0]      haddr_q;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_valid_q;
  logic [31:0]      rd_data_q;

  assign accept    = (state == IDLE) && req_valid;
  assign beat_done = (state == BEAT) && HREADY;
  assign last_beat = !burst_q || (cur_idx == IDX_W'(WORDS_PER_LINE - 1));

`ifdef AHB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit = (state == BEAT) && !HREADY &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts edges spent waiting in the current beat; restarts whenever a new beat begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      abort_q  <= 1'b0;
    end else begin
      if (accept || beat_done)
        wait_cnt <= '0;
      else if (state == BEAT)
        wait_cnt <= wait_cnt + CNT_W'(1);
      if (accept)
        abort_q <= 1'b0;
      else if (timeout_hit)
        abort_q <= 1'b1;
    end
  end
`else
  // TIMEOUT_CYCLES is always positive, so without the counter this is a constant 0.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
  assign abort_q     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = BEAT;
      BEAT:    if ((beat_done && last_beat) || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address phase registers: loaded on accept, advanced only by a completed non-final beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_q  <= 1'b0;
      hwrite_q <= 1'b0;
      hsize_q  <= 3'b000;
      haddr_q  <= 32'd0;
      cur_idx  <= '0;
    end else if (accept) begin
      burst_q  <= req_burst;
      hwrite_q <= req_write;
      cur_idx  <= '0;
      haddr_q  <= req_burst ? (req_addr & LINE_MASK) : req_addr;
      if (req_burst || req_size > 3'b010)
        hsize_q <= 3'b010;
      else
        hsize_q <= req_size;
    end else if (beat_done && !last_beat) begin
      cur_idx <= cur_idx + IDX_W'(1);
      haddr_q <= haddr_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'd0;
      rd_idx     <= '0;
    end else begin
      rd_valid_q <= beat_done && !hwrite_q;
      if (beat_done && !hwrite_q) begin
        rd_data_q <= HRDATA;
        rd_idx    <= cur_idx;
      end
    end
  end

  // beat_idx reports the completed beat while rd_valid is high, the live beat otherwise;
  // HWDATA follows wr_data, which is steady because it is indexed by the registered beat.
  always_comb begin
    req_ready = (state == IDLE);
    HREQUEST  = (state == BEAT);
    done      = (state == DONE);
    err       = (state == DONE) && abort_q;
    HWDATA    = (state == BEAT) ? wr_data : 32'd0;
    HADDR     = haddr_q;
    HWRITE    = hwrite_q;
    HSIZE     = hsize_q;
    rd_valid  = rd_valid_q;
    rd_data   = rd_data_q;
    beat_idx  = rd_valid_q ? rd_idx : cur_idx;
  end

endmodule
